// File: rtl/shift_share_arbiter.sv
// Round-robin arbiter sharing a right-shift-with-sticky datapath between NUM_REQ requesters.
// Two registered stages (operand, result) with valid/ready flow control; results tagged with requester id.
module shift_share_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int IN_WIDTH        = 8,
  parameter int OUT_WIDTH       = 8,
  parameter int SHIFT_VAL_WIDTH = $clog2(OUT_WIDTH + 1),
  parameter int ID_WIDTH        = $clog2(NUM_REQ)
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NUM_REQ-1:0]                 reqValid,
  output logic [NUM_REQ-1:0]                 reqReady,
  input  logic [NUM_REQ*IN_WIDTH-1:0]        reqIn,
  input  logic [NUM_REQ*SHIFT_VAL_WIDTH-1:0] reqShift,
  output logic                               outValid,
  input  logic                               outReady,
  output logic [OUT_WIDTH-1:0]               out,
  output logic                               outSticky,
  output logic                               outStickyAnd,
  output logic [ID_WIDTH-1:0]                outId
);

  localparam int PRIO_WIDTH = $clog2(NUM_REQ);

  logic [PRIO_WIDTH-1:0]      prio_reg;
  logic [PRIO_WIDTH-1:0]      grant_idx;
  logic [PRIO_WIDTH-1:0]      prio_next;
  logic [NUM_REQ-1:0]         grant;
  logic                       any_valid;
  logic [IN_WIDTH-1:0]        sel_data;
  logic [SHIFT_VAL_WIDTH-1:0] sel_shift;

  logic                       s0_valid_reg;
  logic [IN_WIDTH-1:0]        s0_data_reg;
  logic [SHIFT_VAL_WIDTH-1:0] s0_shift_reg;
  logic [ID_WIDTH-1:0]        s0_id_reg;

  logic                       out_valid_reg;
  logic [OUT_WIDTH-1:0]       out_reg;
  logic                       sticky_reg;
  logic                       sticky_and_reg;
  logic [ID_WIDTH-1:0]        out_id_reg;

  logic s1_adv;
  logic s0_adv;

  assign s1_adv = !out_valid_reg | outReady;
  assign s0_adv = !s0_valid_reg | s1_adv;

  // Scan priority order prio, prio+1, ... with wrap; the first valid requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!any_valid && reqValid[i] &&
            ((int'(prio_reg) + k == i) || (int'(prio_reg) + k == i + NUM_REQ))) begin
          any_valid = 1'b1;
          grant[i]  = 1'b1;
          grant_idx = PRIO_WIDTH'(i);
        end
      end
    end
  end

  always_comb begin
    sel_data  = '0;
    sel_shift = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_data  = reqIn[i*IN_WIDTH +: IN_WIDTH];
        sel_shift = reqShift[i*SHIFT_VAL_WIDTH +: SHIFT_VAL_WIDTH];
      end
    end
  end

  assign prio_next = (grant_idx == PRIO_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
  assign reqReady  = grant & {NUM_REQ{s0_adv & !reset}};

  always_ff @(posedge clock) begin
    if (reset) begin
      s0_valid_reg <= 1'b0;
      s0_data_reg  <= '0;
      s0_shift_reg <= '0;
      s0_id_reg    <= '0;
      prio_reg     <= '0;
    end else if (s0_adv) begin
      s0_valid_reg <= any_valid;
      if (any_valid) begin
        s0_data_reg  <= sel_data;
        s0_shift_reg <= sel_shift;
        s0_id_reg    <= ID_WIDTH'(grant_idx);
        prio_reg     <= prio_next;
      end
    end
  end

  // Left-align the operand into OUT_WIDTH bits: truncate low bits or zero-pad on the right.
  logic [OUT_WIDTH-1:0] aligned;
  logic [OUT_WIDTH-1:0] shifted;
  logic [IN_WIDTH-1:0]  discard;
  logic [31:0]          shift_ext;
  logic                 sticky;
  logic                 sticky_and;

  generate
    if (IN_WIDTH >= OUT_WIDTH) begin : g_trunc
      assign aligned = s0_data_reg[IN_WIDTH-1 -: OUT_WIDTH];
    end else begin : g_pad
      assign aligned = {s0_data_reg, {(OUT_WIDTH-IN_WIDTH){1'b0}}};
    end
  endgenerate

  assign shifted   = aligned >> s0_shift_reg;
  assign shift_ext = 32'(s0_shift_reg);

  // Operand bit gi survives only if it lands at or above bit 0 after alignment and shift.
  genvar gi;
  generate
    for (gi = 0; gi < IN_WIDTH; gi++) begin : g_discard
      assign discard[gi] = (32'(gi + OUT_WIDTH)) < (32'(IN_WIDTH) + shift_ext);
    end
  endgenerate

  assign sticky     = |(s0_data_reg & discard);
  assign sticky_and = &(s0_data_reg | ~discard);

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_reg  <= 1'b0;
      out_reg        <= '0;
      sticky_reg     <= 1'b0;
      sticky_and_reg <= 1'b0;
      out_id_reg     <= '0;
    end else if (s1_adv) begin
      out_valid_reg <= s0_valid_reg;
      if (s0_valid_reg) begin
        out_reg        <= shifted;
        sticky_reg     <= sticky;
        sticky_and_reg <= sticky_and;
        out_id_reg     <= s0_id_reg;
      end
    end
  end

  assign outValid     = out_valid_reg;
  assign out          = out_reg;
  assign outSticky    = sticky_reg;
  assign outStickyAnd = sticky_and_reg;
  assign outId        = out_id_reg;

endmodule
